// File: rtl/grf_wb_arbiter_pkg.sv
// Shared CPU definitions for the general register file write port.
package grf_wb_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Register file write port record, shared with the register file.
  typedef struct packed {
    logic              we;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
  } wb_port_t;

  // Multi-cycle result FIFO entry; live drops when a younger pipeline write supersedes it.
  typedef struct packed {
    logic              live;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Multi-cycle result FIFO with push, pop and kill-by-destination-address.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         kill,
  input  logic [ADDR_W-1:0]            kill_a3,
  output logic [CNT_W-1:0]             count,
  output wb_entry_t                    head,
  output logic [DEPTH-1:0]             live_vec,
  output logic [DEPTH-1:0][ADDR_W-1:0] a3_vec
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign head   = mem[rd_idx];

  // Kill existing entries first so a same-cycle push to that register stays live;
  // popped slots drop live so the hazard vector only covers occupied entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill && mem[PTR_W'(i)].a3 == kill_a3) mem[PTR_W'(i)].live <= 1'b0;
      end
      if (pop) begin
        mem[rd_idx].live <= 1'b0;
        rd_ptr           <= rd_ptr + CNT_W'(1);
      end
      if (push) begin
        mem[wr_idx] <= push_entry;
        wr_ptr      <= wr_ptr + CNT_W'(1);
      end
    end
  end

  always_comb begin
    live_vec = '0;
    a3_vec   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live_vec[PTR_W'(i)] = mem[PTR_W'(i)].live;
      a3_vec[PTR_W'(i)]   = mem[PTR_W'(i)].a3;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter: merges pipeline writes with buffered multi-cycle results onto
// the register file's single write port and reports pending writes to decode.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4,
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_we,
  input  logic [PC_W-1:0]   p_pc,
  input  logic [ADDR_W-1:0] p_a3,
  input  logic [DATA_W-1:0] p_wd,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [PC_W-1:0]   m_pc,
  input  logic [ADDR_W-1:0] m_a3,
  input  logic [DATA_W-1:0] m_wd,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic              stall_req,
  output logic              g_we,
  output logic [PC_W-1:0]   g_pc,
  output logic [ADDR_W-1:0] g_a3,
  output logic [DATA_W-1:0] g_wd,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned WAIT_W = 4;

  wb_port_t                    g_q;
  wb_entry_t                   head;
  wb_entry_t                   push_entry;
  logic [DEPTH-1:0]            live_vec;
  logic [DEPTH-1:0][ADDR_W-1:0] a3_vec;
  logic                        p_eff;
  logic                        empty;
  logic                        pop;
  logic                        push;
  logic [WAIT_W-1:0]           wait_cnt;
  logic [WAIT_W-1:0]           wait_next;

  assign p_eff      = p_we && (p_a3 != REG_ZERO);
  assign empty      = (count == '0);
  assign pop        = !p_eff && !empty;
  assign m_ready    = (count < CNT_W'(DEPTH));
  // Results for r0 complete the handshake but are never queued.
  assign push       = m_valid && m_ready && (m_a3 != REG_ZERO);
  assign push_entry = '{live: 1'b1, pc: m_pc, a3: m_a3, wd: m_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (p_eff),
    .kill_a3    (p_a3),
    .count      (count),
    .head       (head),
    .live_vec   (live_vec),
    .a3_vec     (a3_vec)
  );

  // Starvation counter: counts cycles the head loses to the pipeline.
  always_comb begin
    wait_next = wait_cnt;
    if (empty || pop) wait_next = '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_next = wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_q       <= '0;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      wait_cnt  <= wait_next;
      stall_req <= (wait_next == WAIT_W'(MAX_WAIT));
      g_q.we    <= 1'b0;
      if (p_eff) g_q <= '{we: 1'b1, pc: p_pc, a3: p_a3, wd: p_wd};
      else if (pop) g_q <= '{we: head.live, pc: head.pc, a3: head.a3, wd: head.wd};
    end
  end

  assign g_we = g_q.we;
  assign g_pc = g_q.pc;
  assign g_a3 = g_q.a3;
  assign g_wd = g_q.wd;

  // Read-after-write hazard lookup over live FIFO entries and the output stage.
  always_comb begin
    q_hit1 = g_q.we && (g_q.a3 == q_a1);
    q_hit2 = g_q.we && (g_q.a3 == q_a2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_vec[PTR_W'(i)] && a3_vec[PTR_W'(i)] == q_a1) q_hit1 = 1'b1;
      if (live_vec[PTR_W'(i)] && a3_vec[PTR_W'(i)] == q_a2) q_hit2 = 1'b1;
    end
    if (q_a1 == REG_ZERO) q_hit1 = 1'b0;
    if (q_a2 == REG_ZERO) q_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: expected register-file writes are queued by the
// stimulus and consumed by a monitor; state outputs are checked directly.
module tb_grf_wb_arbiter;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             p_we;
  logic [31:0]      p_pc;
  logic [4:0]       p_a3;
  logic [31:0]      p_wd;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_pc;
  logic [4:0]       m_a3;
  logic [31:0]      m_wd;
  logic [4:0]       q_a1;
  logic [4:0]       q_a2;
  logic             q_hit1;
  logic             q_hit2;
  logic             stall_req;
  logic             g_we;
  logic [31:0]      g_pc;
  logic [4:0]       g_a3;
  logic [31:0]      g_wd;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_we      (p_we),
    .p_pc      (p_pc),
    .p_a3      (p_a3),
    .p_wd      (p_wd),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_pc      (m_pc),
    .m_a3      (m_a3),
    .m_wd      (m_wd),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .stall_req (stall_req),
    .g_we      (g_we),
    .g_pc      (g_pc),
    .g_a3      (g_a3),
    .g_wd      (g_wd),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic [4:0] a3, input logic [31:0] wd);
    p_a3 = a3;
    p_wd = wd;
    p_pc = 32'h1000 + 32'(a3);
  endtask

  task automatic set_m(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [31:0] pc);
    m_valid = v;
    m_a3    = a3;
    m_wd    = wd;
    m_pc    = pc;
  endtask

  task automatic exp_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    exp_q.push_back('{a3: a3, wd: wd, pc: pc});
  endtask

  // Monitor: every presented write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (g_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected actual a3=%0d wd=%0h pc=%0h required no write",
                   g_a3, g_wd, g_pc);
        end else begin
          e = exp_q.pop_front();
          if (g_a3 !== e.a3 || g_wd !== e.wd || g_pc !== e.pc) begin
            failures++;
            $display("FAIL wb_write actual a3=%0d wd=%0h pc=%0h required a3=%0d wd=%0h pc=%0h",
                     g_a3, g_wd, g_pc, e.a3, e.wd, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    p_we  = 1'b0;
    set_p(5'd0, 32'h0);
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    q_a1 = 5'd5;
    q_a2 = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    check("rst_g_we", 32'(g_we), 32'd0);
    check("rst_m_ready", 32'(m_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_q_hit1", 32'(q_hit1), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_g_a3", 32'(g_a3), 32'd0);

    // Pipeline write, then a write to r0 that must be ignored
    p_we = 1'b1;
    set_p(5'd8, 32'h1234);
    exp_wr(5'd8, 32'h1234, 32'h1008);
    tick();
    check("p_g_we", 32'(g_we), 32'd1);
    check("p_g_a3", 32'(g_a3), 32'd8);
    check("p_g_wd", g_wd, 32'h1234);
    q_a1 = 5'd8;
    #1;
    check("p_hit_gstage", 32'(q_hit1), 32'd1);
    set_p(5'd0, 32'h5555);
    tick();
    check("p_r0_g_we", 32'(g_we), 32'd0);
    p_we = 1'b0;

    // Multi-cycle result with no competing pipeline writes
    set_m(1'b1, 5'd9, 32'hAB, 32'h200);
    exp_wr(5'd9, 32'hAB, 32'h200);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    q_a1 = 5'd9;
    #1;
    check("m_count_push", 32'(count), 32'd1);
    check("m_hit_fifo", 32'(q_hit1), 32'd1);
    check("m_g_we_early", 32'(g_we), 32'd0);
    tick();
    check("m_g_we", 32'(g_we), 32'd1);
    check("m_g_a3", 32'(g_a3), 32'd9);
    check("m_count_pop", 32'(count), 32'd0);
    check("m_hit_gstage", 32'(q_hit1), 32'd1);
    tick();
    check("m_g_we_after", 32'(g_we), 32'd0);
    check("m_hit_clear", 32'(q_hit1), 32'd0);

    // Fill while the pipeline keeps winning; starvation guard
    p_we = 1'b1;
    set_p(5'd1, 32'h11);
    exp_wr(5'd1, 32'h11, 32'h1001);
    set_m(1'b1, 5'd10, 32'hA0, 32'h300);
    tick();
    check("fill_count1", 32'(count), 32'd1);
    set_p(5'd2, 32'h12);
    exp_wr(5'd2, 32'h12, 32'h1002);
    set_m(1'b1, 5'd11, 32'hA1, 32'h301);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("fill_m_ready", 32'(m_ready), 32'd0);
    check("fill_count2", 32'(count), 32'd2);
    check("fill_stall0", 32'(stall_req), 32'd0);
    for (int k = 3; k <= 5; k++) begin
      set_p(5'(k), 32'h10 + 32'(k));
      exp_wr(5'(k), 32'h10 + 32'(k), 32'h1000 + 32'(k));
      tick();
      check("stall_ramp", 32'(stall_req), (k == 5) ? 32'd1 : 32'd0);
    end
    // Pipeline write while stalled still wins
    set_p(5'd6, 32'h16);
    exp_wr(5'd6, 32'h16, 32'h1006);
    tick();
    check("stall_p_wins_a3", 32'(g_a3), 32'd6);
    check("stall_held", 32'(stall_req), 32'd1);
    // Drain; a push offered while full is refused on the popping edge
    p_we = 1'b0;
    set_m(1'b1, 5'd12, 32'hA2, 32'h302);
    exp_wr(5'd10, 32'hA0, 32'h300);
    exp_wr(5'd11, 32'hA1, 32'h301);
    exp_wr(5'd12, 32'hA2, 32'h302);
    tick();
    check("full_refused_count", 32'(count), 32'd1);
    check("drain_stall_clear", 32'(stall_req), 32'd0);
    check("drain_first_a3", 32'(g_a3), 32'd10);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    check("push_pop_count", 32'(count), 32'd1);
    tick();
    check("drain_count0", 32'(count), 32'd0);
    check("drain_last_a3", 32'(g_a3), 32'd12);
    tick();
    check("drain_idle", 32'(g_we), 32'd0);

    // Result for r0 is accepted and dropped
    set_m(1'b1, 5'd0, 32'hEE, 32'h3FF);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    check("m_r0_count", 32'(count), 32'd0);

    // Write-after-write kill; same-cycle push to the killed register stays live
    set_m(1'b1, 5'd4, 32'hC4, 32'h400);
    tick();
    set_m(1'b1, 5'd4, 32'hD4, 32'h600);
    p_we = 1'b1;
    set_p(5'd4, 32'hB4);
    exp_wr(5'd4, 32'hB4, 32'h1004);
    exp_wr(5'd4, 32'hD4, 32'h600);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    p_we = 1'b0;
    q_a1 = 5'd4;
    #1;
    check("kill_p_wd", g_wd, 32'hB4);
    check("kill_count", 32'(count), 32'd2);
    check("kill_hit", 32'(q_hit1), 32'd1);
    tick();
    check("killed_pop_g_we", 32'(g_we), 32'd0);
    check("killed_pop_count", 32'(count), 32'd1);
    check("kill_new_live_hit", 32'(q_hit1), 32'd1);
    tick();
    check("kill_new_wd", g_wd, 32'hD4);
    check("kill_count0", 32'(count), 32'd0);
    tick();
    check("kill_hit_clear", 32'(q_hit1), 32'd0);

    // Reset with two entries queued discards them
    p_we = 1'b1;
    set_p(5'd30, 32'h30);
    exp_wr(5'd30, 32'h30, 32'h101E);
    set_m(1'b1, 5'd21, 32'hF1, 32'h700);
    tick();
    set_p(5'd31, 32'h31);
    exp_wr(5'd31, 32'h31, 32'h101F);
    set_m(1'b1, 5'd22, 32'hF2, 32'h701);
    tick();
    set_m(1'b0, 5'd0, 32'h0, 32'h0);
    p_we = 1'b0;
    check("pre_reset_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_g_we", 32'(g_we), 32'd0);
    check("mid_reset_m_ready", 32'(m_ready), 32'd1);
    reset = 1'b0;
    repeat (4) tick();
    check("post_reset_count", 32'(count), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-back arbiter for the general register file's single write port. It merges the in-order pipeline write-back stream with results from a multi-cycle unit (mult/div, long-latency load), buffering the latter in a small FIFO. It drives the register file's we/a3/wd/pc port from a registered output stage, and reports pending writes so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 2: entries in the multi-cycle result FIFO; power of two, 2..8.
- MAX_WAIT, 4: number of cycles the FIFO head may be blocked by pipeline writes before stall_req asserts; 1..15.

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- p_we  in  1  pipeline write-back enable.
- p_pc  in  32  PC of the pipeline instruction.
- p_a3  in  5  pipeline destination register.
- p_wd  in  32  pipeline write data.
- m_valid  in  1  multi-cycle result valid.
- m_ready  out  1  FIFO can accept; equals count < DEPTH.
- m_pc  in  32  PC of the multi-cycle instruction.
- m_a3  in  5  multi-cycle destination register.
- m_wd  in  32  multi-cycle write data.
- q_a1  in  5  decode read address 1.
- q_a2  in  5  decode read address 2.
- q_hit1  out  1  write to q_a1 is pending; combinational.
- q_hit2  out  1  write to q_a2 is pending; combinational.
- stall_req  out  1  registered; upstream must hold p_we low while it is high.
- g_we  out  1  register file write enable; registered.
- g_pc  out  32  register file pc; registered.
- g_a3  out  5  register file write address; registered.
- g_wd  out  32  register file write data; registered.
- count  out  log2(DEPTH)+1  number of FIFO entries, live or killed.

## Operation
- Effective pipeline write: p_we && p_a3 != 0. A pipeline write with a3 == 0 is ignored entirely.
- Push happens when m_valid && m_ready.
  - An m result with m_a3 == 0 is accepted and discarded; it is not enqueued.
- Each entry holds {live, pc, a3, wd}. A push sets live = 1.
- Output selection each cycle, in priority order:
  1. An effective pipeline write loads g_* from p_* with g_we = 1.
  2. Otherwise, if the FIFO is non-empty, pop the head. g_* loads from the head, with g_we = head.live.
  3. Otherwise g_we = 0, and g_pc/g_a3/g_wd hold their values.
- Write-after-write kill: an effective pipeline write clears live on every FIFO entry whose a3 equals p_a3, in the same cycle.
  - A killed entry is still popped in turn, with g_we = 0, consuming one output slot.
- Starvation guard:
  - wait_cnt increments each cycle the FIFO is non-empty and a pipeline write wins.
  - wait_cnt clears on any pop or when the FIFO is empty, and saturates at MAX_WAIT.
  - stall_req = (wait_cnt == MAX_WAIT), registered.
  - p_we high while stall_req is high is a protocol violation. The pipeline still wins; the bench asserts this case.
- Hazard lookup: q_hitN = q_aN != 0 && (any live entry has a3 == q_aN, or g_we && g_a3 == q_aN).

## Timing
- Reset values: g_we 0, g_pc/g_a3/g_wd 0, FIFO empty, count 0, m_ready 1, stall_req 0, wait_cnt 0.
  - Reset mid-operation discards all queued entries and produces no write.
- Latency:
  - Pipeline path: 1 cycle from p_* to g_*.
  - m path: at least 2 cycles, since push and pop happen on different edges; there is no bypass.
- m_ready is derived from the registered count.
  - When the FIFO is full, a push is refused even if a pop occurs that cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Pointers wrap modulo DEPTH, with an extra count bit to distinguish full from empty.
- A kill and a push to the same register in the same cycle: the kill applies only to existing entries; the new entry stays live.
- Once m_valid is high it must stay high, with stable data, until accepted.

## Structure
- Shared CPU package holds:
  - REG_ZERO = 5'd0
  - ADDR_W = 5
  - DATA_W = 32
  - The write-port record type {we, pc, a3, wd}, which this block and the register file share.
- One sub-module, wb_fifo:
  - DEPTH entries, with push, pop, and kill-by-address.
  - Exposes its live/a3 vectors for the hazard comparators.
  - The arbiter holds priority, the output register, wait_cnt and the hazard OR.

## Test plan
- Reset, then idle: g_we = 0, m_ready = 1, count = 0, q_hit1 = 0 for q_a1 = 5.
- Pipeline write p_a3 = 8, p_wd = 32'h1234: one cycle later g_we = 1, g_a3 = 8, g_wd = 32'h1234. A write with p_a3 = 0 gives g_we = 0.
- Push m (a3 = 9, wd = 32'hAB) with no pipeline writes:
  - count reads 1 after the push edge, and q_hit1 = 1 for q_a1 = 9.
  - Two cycles after the push, g_we = 1, g_a3 = 9.
  - q_hit1 stays high through the g stage and drops after.
- Fill the FIFO with DEPTH pushes while p_we is held high: m_ready = 0, and stall_req rises after MAX_WAIT cycles. With p_we dropped, entries drain in push order and stall_req clears.
- Queue m to a3 = 4, then a pipeline write to a3 = 4: the pipeline value is written, and the later pop gives g_we = 0, so register 4 keeps the pipeline value.
- Assert reset with 2 entries queued: count = 0 and g_we = 0 next cycle, and no queued write ever appears.
